// File: rtl/axis_custom_pkg.sv
// Shared constants and reader state encoding for the AXI-stream/BRAM bridge.
package axis_custom_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 9;
  localparam int NUM_BRAM = 8;
  localparam int SEL_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;
endpackage

// File: rtl/bram_axis_reader_if.sv
// AXI4-Stream channel bundle used for the reader's MM2S output.
interface bram_axis_reader_if #(
  parameter int DATA_W = axis_custom_pkg::DATA_W
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_fifo2.sv
// Two-entry registered FIFO with an AXIS-style output side and an occupancy count.
module axis_fifo2 #(
  parameter int DATA_W = axis_custom_pkg::DATA_W
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        count
);
  logic [DATA_W-1:0] mem_reg [2];
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [1:0]        count_reg;
  logic              push;
  logic              pop;

  assign out_valid = (count_reg != 2'd0);
  assign out_data  = mem_reg[rd_ptr_reg];
  assign count     = count_reg;
  assign pop       = out_valid && out_ready;
  // Writes into a full FIFO are dropped; the producer is expected to track count.
  assign push      = in_valid && (count_reg != 2'd2);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 2; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= in_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/bram_axis_reader.sv
// Streams a window of BRAM banks out on AXI4-Stream, bank by bank and address by address.
module bram_axis_reader #(
  parameter int DATA_W   = axis_custom_pkg::DATA_W,
  parameter int ADDR_W   = axis_custom_pkg::ADDR_W,
  parameter int NUM_BRAM = axis_custom_pkg::NUM_BRAM,
  parameter int SEL_W    = axis_custom_pkg::SEL_W
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               start,
  input  logic [SEL_W-1:0]   rd_bram_start,
  input  logic [SEL_W-1:0]   rd_bram_end,
  input  logic [15:0]        rd_addr_start,
  input  logic [15:0]        rd_addr_count,
  output logic [ADDR_W-1:0]  bram_rd_addr,
  input  logic [DATA_W-1:0]  bram_rd_data_0,
  input  logic [DATA_W-1:0]  bram_rd_data_1,
  input  logic [DATA_W-1:0]  bram_rd_data_2,
  input  logic [DATA_W-1:0]  bram_rd_data_3,
  input  logic [DATA_W-1:0]  bram_rd_data_4,
  input  logic [DATA_W-1:0]  bram_rd_data_5,
  input  logic [DATA_W-1:0]  bram_rd_data_6,
  input  logic [DATA_W-1:0]  bram_rd_data_7,
  bram_axis_reader_if.master m_axis,
  output logic               busy,
  output logic               read_done
);
  import axis_custom_pkg::*;

  rd_state_t         state_reg, state_next;
  logic [SEL_W-1:0]  bank_reg, bank_end_reg, tag_sel_reg;
  logic [ADDR_W-1:0] addr_reg, addr_start_reg;
  logic [15:0]       word_count_reg, words_left_reg;
  logic [18:0]       beats_left_reg;
  logic              tag_valid_reg;
  logic [DATA_W-1:0] bank_data [NUM_BRAM];
  logic [DATA_W-1:0] mux_data, fifo_data;
  logic [1:0]        fifo_count;
  logic              fifo_valid, pop, issue, last_issue, degenerate, accept;
  logic [2:0]        occupancy;
  logic [18:0]       span, total;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^rd_addr_start[15:ADDR_W];

  assign bank_data[0] = bram_rd_data_0;
  assign bank_data[1] = bram_rd_data_1;
  assign bank_data[2] = bram_rd_data_2;
  assign bank_data[3] = bram_rd_data_3;
  assign bank_data[4] = bram_rd_data_4;
  assign bank_data[5] = bram_rd_data_5;
  assign bank_data[6] = bram_rd_data_6;
  assign bank_data[7] = bram_rd_data_7;
  // The tag follows the read through the BRAM's one-cycle latency.
  assign mux_data = bank_data[tag_sel_reg];

  axis_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (tag_valid_reg),
    .in_data   (mux_data),
    .out_valid (fifo_valid),
    .out_data  (fifo_data),
    .out_ready (m_axis.tready),
    .count     (fifo_count)
  );

  assign pop        = fifo_valid && m_axis.tready;
  // A word leaving this cycle frees its slot, which keeps 1 word/cycle under full ready.
  assign occupancy  = 3'(fifo_count) + 3'(tag_valid_reg) - 3'(pop);
  assign issue      = (state_reg == ST_READ) && (occupancy < 3'd2);
  assign last_issue = issue && (words_left_reg == 16'd1) && (bank_reg == bank_end_reg);
  assign accept     = (state_reg == ST_IDLE) && start;
  assign degenerate = (rd_addr_count == 16'd0) || (rd_bram_end < rd_bram_start);
  assign span       = 19'(rd_bram_end) - 19'(rd_bram_start) + 19'd1;
  assign total      = span * 19'(rd_addr_count);

  assign bram_rd_addr  = addr_reg;
  assign m_axis.tvalid = fifo_valid;
  assign m_axis.tdata  = fifo_data;
  assign m_axis.tlast  = fifo_valid && (beats_left_reg == 19'd1);
  assign busy          = (state_reg == ST_READ) || (state_reg == ST_DRAIN);
  assign read_done     = (state_reg == ST_DONE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = degenerate ? ST_DONE : ST_READ;
      ST_READ:  if (last_issue) state_next = ST_DRAIN;
      ST_DRAIN: if (pop && (beats_left_reg == 19'd1)) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg      <= ST_IDLE;
      bank_reg       <= '0;
      bank_end_reg   <= '0;
      addr_reg       <= '0;
      addr_start_reg <= '0;
      word_count_reg <= '0;
      words_left_reg <= '0;
      beats_left_reg <= '0;
      tag_valid_reg  <= 1'b0;
      tag_sel_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      tag_valid_reg <= issue;
      tag_sel_reg   <= bank_reg;
      if (accept) begin
        bank_reg       <= rd_bram_start;
        bank_end_reg   <= rd_bram_end;
        addr_start_reg <= rd_addr_start[ADDR_W-1:0];
        addr_reg       <= rd_addr_start[ADDR_W-1:0];
        word_count_reg <= rd_addr_count;
        words_left_reg <= rd_addr_count;
        beats_left_reg <= degenerate ? 19'd0 : total;
      end else begin
        if (issue && !last_issue) begin
          if (words_left_reg == 16'd1) begin
            bank_reg       <= bank_reg + SEL_W'(1);
            words_left_reg <= word_count_reg;
            addr_reg       <= addr_start_reg;
          end else begin
            words_left_reg <= words_left_reg - 16'd1;
            addr_reg       <= addr_reg + ADDR_W'(1);
          end
        end
        if (pop) beats_left_reg <= beats_left_reg - 19'd1;
      end
    end
  end
endmodule

// File: tb/tb_bram_axis_reader.sv
// Directed bench for bram_axis_reader: queue-based beat model plus per-command timing checks.
module tb_bram_axis_reader;
  typedef struct {
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start;
  logic [2:0]  rd_bram_start, rd_bram_end;
  logic [15:0] rd_addr_start, rd_addr_count;
  logic [8:0]  bram_rd_addr;
  logic [15:0] bram_q [8];
  logic        busy, read_done;

  bram_axis_reader_if #(.DATA_W(16)) m_axis ();

  bram_axis_reader dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .start          (start),
    .rd_bram_start  (rd_bram_start),
    .rd_bram_end    (rd_bram_end),
    .rd_addr_start  (rd_addr_start),
    .rd_addr_count  (rd_addr_count),
    .bram_rd_addr   (bram_rd_addr),
    .bram_rd_data_0 (bram_q[0]),
    .bram_rd_data_1 (bram_q[1]),
    .bram_rd_data_2 (bram_q[2]),
    .bram_rd_data_3 (bram_q[3]),
    .bram_rd_data_4 (bram_q[4]),
    .bram_rd_data_5 (bram_q[5]),
    .bram_rd_data_6 (bram_q[6]),
    .bram_rd_data_7 (bram_q[7]),
    .m_axis         (m_axis),
    .busy           (busy),
    .read_done      (read_done)
  );

  initial forever #5 aclk = ~aclk;

  int          vectors = 0;
  int          miscompares = 0;
  int          data_mode = 0;
  int          beats_seen = 0;
  bit          addr_chk_en = 0;
  beat_t       exp_q [$];
  logic [15:0] obs_q [$];
  bit          hold_pending = 0;
  logic [15:0] held_data;
  logic        held_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mode 0: every bank returns addr+1. Mode 1: bank b returns {b[6:0], addr}.
  function automatic logic [15:0] bram_fn(input int b, input logic [8:0] a);
    logic [6:0] bb;
    bb = 7'(b);
    if (data_mode == 0) return 16'(a) + 16'd1;
    return {bb, a};
  endfunction

  always @(posedge aclk)
    for (int b = 0; b < 8; b++) bram_q[b] <= bram_fn(b, bram_rd_addr);

  function automatic logic ready_fn(input int mode, input int n);
    if (mode == 0) return 1'b1;
    if (n < 5) return 1'b1;
    if (n <= 14) return 1'b0;
    return ((n - 15) % 2) == 0;
  endfunction

  task automatic build_expected(input int bs, input int be, input int as, input int cnt);
    int total;
    int idx;
    beat_t e;
    exp_q.delete();
    if (cnt == 0 || be < bs) return;
    total = (be - bs + 1) * cnt;
    idx = 0;
    for (int b = bs; b <= be; b++) begin
      for (int k = 0; k < cnt; k++) begin
        idx++;
        e.data = bram_fn(b, 9'((as + k) % 512));
        e.last = (idx == total);
        exp_q.push_back(e);
      end
    end
  endtask

  // Compare process: every handshake against the model, hold stability, read-ahead bound.
  always @(negedge aclk) begin
    if (!aresetn) begin
      hold_pending = 0;
    end else begin
      if (hold_pending) begin
        chk("hold_tvalid", m_axis.tvalid, 1);
        chk("hold_tdata", m_axis.tdata, held_data);
        chk("hold_tlast", m_axis.tlast, held_last);
      end
      if (addr_chk_en && busy)
        chk("addr_lead_ok", (int'(bram_rd_addr) <= beats_seen + 2) ? 1 : 0, 1);
      if (m_axis.tvalid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_tvalid", m_axis.tvalid, 0);
        end else if (m_axis.tready) begin
          chk("tdata", m_axis.tdata, exp_q[0].data);
          chk("tlast", m_axis.tlast, exp_q[0].last);
          void'(exp_q.pop_front());
        end
        if (m_axis.tready) begin
          obs_q.push_back(m_axis.tdata);
          beats_seen = beats_seen + 1;
        end
      end
      hold_pending = m_axis.tvalid && !m_axis.tready;
      held_data = m_axis.tdata;
      held_last = m_axis.tlast;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, m_axis.tvalid, 0);
    chk({tag, "_tlast"}, m_axis.tlast, 0);
    chk({tag, "_tdata"}, m_axis.tdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_read_done"}, read_done, 0);
    chk({tag, "_bram_rd_addr"}, bram_rd_addr, 0);
  endtask

  // Runs one command. done_at/first_at count clock edges after E0 (-1 if never seen).
  task automatic run_cmd(input int bs, input int be, input int as, input int cnt,
                         input int rmode, input int restart_at, input int reset_at,
                         output int done_at, output int first_at);
    int n;
    bit deg;
    bit stop;
    deg = (cnt == 0) || (be < bs);
    @(posedge aclk); #1;
    rd_bram_start = 3'(bs);
    rd_bram_end   = 3'(be);
    rd_addr_start = 16'(as);
    rd_addr_count = 16'(cnt);
    build_expected(bs, be, as, cnt);
    beats_seen = 0;
    obs_q.delete();
    m_axis.tready = 1'b1;
    start = 1'b1;
    @(posedge aclk); #1;
    n = 0;
    done_at = -1;
    first_at = -1;
    stop = 0;
    while (!stop) begin
      start = (n == restart_at);
      if (start) begin
        rd_bram_start = 3'd7;
        rd_bram_end   = 3'd7;
        rd_addr_count = 16'd2;
      end
      m_axis.tready = ready_fn(rmode, n);
      if (n == reset_at) begin
        chk("beats_before_reset", beats_seen, 5);
        #2 aresetn = 1'b0;
        #1 chk_reset_outputs("async_reset");
        exp_q.delete();
        @(posedge aclk); #1 aresetn = 1'b1;
        @(negedge aclk);
        chk("no_done_after_reset", read_done, 0);
        stop = 1;
      end else begin
        @(negedge aclk);
        if (n == 0) chk("busy_after_E0", busy, deg ? 0 : 1);
        if (m_axis.tvalid && first_at < 0) first_at = n;
        if (read_done) begin
          done_at = n;
          chk("busy_at_done", busy, 0);
          stop = 1;
        end else begin
          @(posedge aclk); #1;
          n++;
          if (n > 6000) begin
            chk("done_timeout", 0, 1);
            stop = 1;
          end
        end
      end
    end
    start = 1'b0;
    if (reset_at < 0 && done_at >= 0) begin
      chk("beats_left_in_model", exp_q.size(), 0);
      @(posedge aclk);
      @(negedge aclk);
      chk("done_pulse_width", read_done, 0);
    end
    $display("cmd banks %0d..%0d addr %0d count %0d: %0d beats, done at edge %0d",
             bs, be, as, cnt, beats_seen, done_at);
  endtask

  initial begin
    int d, f;
    aresetn = 1'b0;
    start = 1'b0;
    rd_bram_start = '0;
    rd_bram_end = '0;
    rd_addr_start = '0;
    rd_addr_count = '0;
    m_axis.tready = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk_reset_outputs("reset");
    @(posedge aclk); #1 aresetn = 1'b1;

    // Single bank: data 1..4, first beat after E2, done after E6.
    data_mode = 0;
    run_cmd(0, 0, 0, 4, 0, -1, -1, d, f);
    chk("t1_done_edge", d, 6);
    chk("t1_first_valid_edge", f, 2);
    chk("t1_beats", beats_seen, 4);
    for (int i = 0; i < 4; i++) chk("t1_obs_literal", (i < obs_q.size()) ? obs_q[i] : 16'hxxxx, i + 1);

    // Bank span with 9-bit address wrap.
    data_mode = 1;
    run_cmd(2, 4, 510, 3, 0, -1, -1, d, f);
    chk("t2_done_edge", d, 11);
    chk("t2_beats", beats_seen, 9);
    chk("t2_obs0_literal", (obs_q.size() > 0) ? obs_q[0] : 16'hxxxx, 16'h05FE);
    chk("t2_obs2_literal", (obs_q.size() > 2) ? obs_q[2] : 16'hxxxx, 16'h0400);
    chk("t2_obs8_literal", (obs_q.size() > 8) ? obs_q[8] : 16'hxxxx, 16'h0800);

    // Backpressure: low for cycles 5..14, then alternating.
    data_mode = 0;
    addr_chk_en = 1;
    run_cmd(0, 0, 0, 20, 1, -1, -1, d, f);
    addr_chk_en = 0;
    chk("t3_beats", beats_seen, 20);
    chk("t3_completed", (d > 0) ? 1 : 0, 1);
    chk("t3_obs19_literal", (obs_q.size() > 19) ? obs_q[19] : 16'hxxxx, 20);

    // Degenerate commands.
    run_cmd(0, 0, 0, 0, 0, -1, -1, d, f);
    chk("t4a_done_edge", d, 0);
    chk("t4a_no_valid", f, -1);
    run_cmd(5, 3, 0, 4, 0, -1, -1, d, f);
    chk("t4b_done_edge", d, 0);
    chk("t4b_no_valid", f, -1);
    chk("t4b_beats", beats_seen, 0);

    // Start pulse while busy is ignored and config changes have no effect.
    run_cmd(0, 0, 0, 6, 0, 3, -1, d, f);
    chk("t5a_done_edge", d, 8);
    chk("t5a_beats", beats_seen, 6);

    // Asynchronous reset while beat 6 is on the bus, then a fresh transfer.
    run_cmd(0, 0, 0, 10, 0, -1, 7, d, f);
    run_cmd(0, 0, 0, 4, 0, -1, -1, d, f);
    chk("t5c_done_edge", d, 6);
    chk("t5c_first_valid_edge", f, 2);
    chk("t5c_obs0_literal", (obs_q.size() > 0) ? obs_q[0] : 16'hxxxx, 1);

    // Full sweep: 8 banks x 512 words; read_done in the (4096+3)th cycle after E0.
    data_mode = 1;
    run_cmd(0, 7, 0, 512, 0, -1, -1, d, f);
    chk("t6_done_edge", d, 4096 + 2);
    chk("t6_first_valid_edge", f, 2);
    chk("t6_beats", beats_seen, 4096);
    chk("t6_obs_last_literal", (obs_q.size() > 4095) ? obs_q[4095] : 16'hxxxx, 16'h0FFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
